// File: rtl/rx_word_align_ctrl_pkg.sv
// Shared types and constants for the receive word-alignment controller.
package rx_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_ERROR  = 3'd5
  } align_state_t;

  // Default training word; all 8 rotations are distinct.
  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'h68;

  // Counter widths.
  localparam int MATCH_CNT_W  = 8;
  localparam int MISS_CNT_W   = 4;
  localparam int SETTLE_CNT_W = 4;
  localparam int ATTEMPT_W    = 4;

  // Slips tried before giving up: one per remaining phase of an 8-bit word.
  localparam int MAX_ATTEMPTS = 7;

endpackage

// File: rtl/rx_word_align_ctrl.sv
// Word-alignment controller: slips the IOD until the training word is seen
// on the right boundary, declares lock, forwards data and watches for loss
// of lock while the link is still sending training.
module rx_word_align_ctrl
  import rx_align_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter int         LOCK_COUNT    = 16,
  parameter int         LOSS_COUNT    = 4,
  parameter int         SLIP_SETTLE   = 4
) (
  input  logic       SCLK,
  input  logic       RESETN,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       train_en,
  output logic       bitslip,
  output logic       aligned,
  output logic       align_err,
  output logic [2:0] slip_cnt,
  output logic [7:0] data_out,
  output logic       data_valid
);

  localparam logic [MATCH_CNT_W-1:0]  LOCK_LAST    = MATCH_CNT_W'(LOCK_COUNT - 1);
  localparam logic [MISS_CNT_W-1:0]   MISS_LAST    = MISS_CNT_W'(LOSS_COUNT - 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST  = SETTLE_CNT_W'(SLIP_SETTLE - 1);
  localparam logic [ATTEMPT_W-1:0]    ATTEMPT_LAST = ATTEMPT_W'(MAX_ATTEMPTS);

  align_state_t state, state_next;

  logic [MATCH_CNT_W-1:0]  match_cnt;
  logic [MISS_CNT_W-1:0]   miss_cnt;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic [ATTEMPT_W-1:0]    attempts;
  logic                    word_match;

  assign word_match = (rx_data == TRAIN_PATTERN);

  // State register.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state decision; dropping train_en during acquisition wins over any
  // lock or slip decision taken in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (train_en) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (!train_en) begin
          state_next = ST_IDLE;
        end else if (rx_valid) begin
          if (word_match) begin
            if (match_cnt == LOCK_LAST) state_next = ST_LOCKED;
          end else if (attempts == ATTEMPT_LAST) begin
            state_next = ST_ERROR;
          end else begin
            state_next = ST_SLIP;
          end
        end
      end
      ST_SLIP: begin
        state_next = train_en ? ST_SETTLE : ST_IDLE;
      end
      ST_SETTLE: begin
        if (!train_en)                       state_next = ST_IDLE;
        else if (settle_cnt == SETTLE_LAST)  state_next = ST_CHECK;
      end
      ST_LOCKED: begin
        // Payload mode (train_en low) never leaves lock.
        if (train_en && rx_valid && !word_match && (miss_cnt == MISS_LAST))
          state_next = ST_CHECK;
      end
      ST_ERROR: begin
        if (!train_en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state; bitslip is suppressed when train_en
  // has already dropped so an abandoned slip never reaches the IOD.
  always_comb begin
    bitslip   = (state == ST_SLIP) && train_en;
    aligned   = (state == ST_LOCKED);
    align_err = (state == ST_ERROR);
  end

  // Match, miss, settle, attempt and slip-phase counters. Everything clears on
  // the way into IDLE so the outputs are already zero in the first IDLE cycle.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      match_cnt  <= '0;
      miss_cnt   <= '0;
      settle_cnt <= '0;
      attempts   <= '0;
      slip_cnt   <= '0;
    end else if (state_next == ST_IDLE) begin
      match_cnt  <= '0;
      miss_cnt   <= '0;
      settle_cnt <= '0;
      attempts   <= '0;
      slip_cnt   <= '0;
    end else begin
      case (state)
        ST_CHECK: begin
          if (rx_valid) begin
            if (!word_match)              match_cnt <= '0;
            else if (match_cnt != '1)     match_cnt <= match_cnt + 1'b1;
          end
        end
        ST_SLIP: begin
          slip_cnt   <= slip_cnt + 3'd1;
          settle_cnt <= '0;
          if (attempts != '1) attempts <= attempts + 1'b1;
        end
        ST_SETTLE: begin
          if (settle_cnt != '1) settle_cnt <= settle_cnt + 1'b1;
        end
        ST_LOCKED: begin
          // Re-acquisition after loss starts with a fresh attempt budget.
          match_cnt <= '0;
          attempts  <= '0;
          if (train_en && rx_valid) begin
            if (word_match)               miss_cnt <= '0;
            else if (miss_cnt == MISS_LAST) miss_cnt <= '0;
            else                          miss_cnt <= miss_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Forwarded data; valid uses the registered lock so the lock-completing
  // word is not marked valid.
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_out   <= rx_data;
      data_valid <= rx_valid & aligned;
    end
  end

endmodule

// File: tb/tb_rx_word_align_ctrl.sv
// Directed bench for rx_word_align_ctrl with an emulated slipping source.
module tb_rx_word_align_ctrl;

  logic       SCLK = 1'b0;
  logic       RESETN;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       train_en;
  logic       bitslip;
  logic       aligned;
  logic       align_err;
  logic [2:0] slip_cnt;
  logic [7:0] data_out;
  logic       data_valid;

  rx_word_align_ctrl dut (
    .SCLK       (SCLK),
    .RESETN     (RESETN),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .train_en   (train_en),
    .bitslip    (bitslip),
    .aligned    (aligned),
    .align_err  (align_err),
    .slip_cnt   (slip_cnt),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  always #5 SCLK = ~SCLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         pulses   = 0;
  int         last_pulse = 0;
  int         min_gap  = 1000;
  int         rot      = 0;
  bit         use_rot  = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       drv_valid = 1'b0;
  logic       drv_train = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int r);
    logic [15:0] t;
    t = {x, x} << r;
    return t[15:8];
  endfunction

  // One clock: drive just after the rising edge, sample on the falling edge.
  // A sampled bitslip rotates the emulated source back by one bit.
  task automatic cycle();
    @(posedge SCLK);
    #1;
    rx_data  = use_rot ? rotl8(8'h68, rot) : drv_data;
    rx_valid = drv_valid;
    train_en = drv_train;
    @(negedge SCLK);
    cyc++;
    if (bitslip === 1'b1) begin
      if (pulses > 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      pulses++;
      last_pulse = cyc;
      rot = (rot + 7) % 8;
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_bitslip"},    bitslip,    0);
    check({pfx, "_aligned"},    aligned,    0);
    check({pfx, "_align_err"},  align_err,  0);
    check({pfx, "_slip_cnt"},   slip_cnt,   0);
    check({pfx, "_data_out"},   data_out,   0);
    check({pfx, "_data_valid"}, data_valid, 0);
  endtask

  task automatic apply_reset();
    RESETN    = 1'b0;
    drv_train = 1'b0;
    drv_valid = 1'b0;
    drv_data  = 8'h00;
    use_rot   = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    train_en  = 1'b0;
    @(posedge SCLK);
    @(posedge SCLK);
    #3 RESETN = 1'b1;
    pulses  = 0;
    min_gap = 1000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] prev_d;
    logic       prev_v;

    RESETN   = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    train_en = 1'b0;
    #2 RESETN = 1'b0;
    #1 check_zero("reset");
    @(posedge SCLK);
    @(posedge SCLK);
    #3 RESETN = 1'b1;

    // Already aligned: lock on the cycle after the 16th compared word.
    drv_train = 1'b1; drv_valid = 1'b1; drv_data = 8'h68; use_rot = 1'b0;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (aligned === 1'b1) begin n = i; break; end
    end
    check("t1_lock_cycle", n, 18);
    check("t1_pulses", pulses, 0);
    check("t1_slip_cnt", slip_cnt, 0);
    check("t1_first_valid", data_valid, 0);
    cycle();
    check("t1_valid_after", data_valid, 1);
    check("t1_data_out", data_out, 8'h68);

    // 3 misses, 1 match, 4 misses: lock holds, then drops after the 4th.
    drv_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_burst1_aligned", aligned, 1);
    end
    drv_data = 8'h68;
    cycle();
    check("t4_match_aligned", aligned, 1);
    drv_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t4_burst2_aligned", aligned, 1);
    end
    drv_data = 8'h68;
    cycle();
    check("t4_drop", aligned, 0);
    check("t4_drop_slip_cnt", slip_cnt, 0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (aligned === 1'b1) begin n = i; break; end
    end
    check("t4_relock_cycle", n, 16);

    // Payload mode: lock held, data delayed by one cycle.
    prev_d = 8'h68; prev_v = 1'b1;
    drv_train = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drv_data  = 8'($urandom);
      drv_valid = 1'($urandom);
      cycle();
      check("t5_aligned", aligned, 1);
      check("t5_data_out", data_out, prev_d);
      check("t5_data_valid", data_valid, prev_v);
      prev_d = drv_data;
      prev_v = drv_valid;
    end
    check("t5_bitslip", pulses, 0);

    // Pattern rotated by 3.
    apply_reset();
    use_rot = 1'b1; rot = 3; drv_train = 1'b1; drv_valid = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      cycle();
      if (aligned === 1'b1) break;
    end
    check("t2_pulses", pulses, 3);
    check("t2_min_gap", min_gap, 6);
    check("t2_slip_cnt", slip_cnt, 3);
    check("t2_aligned", aligned, 1);
    check("t2_align_err", align_err, 0);

    // Constant zero: 7 slips then error, cleared by dropping train_en.
    apply_reset();
    drv_data = 8'h00; drv_train = 1'b1; drv_valid = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      cycle();
      if (align_err === 1'b1) break;
    end
    check("t3_pulses", pulses, 7);
    check("t3_align_err", align_err, 1);
    check("t3_aligned", aligned, 0);
    check("t3_slip_cnt", slip_cnt, 7);
    drv_train = 1'b0;
    cycle();
    check("t3_err_sticky", align_err, 1);
    cycle();
    check_zero("t3_idle");

    // Reset during SETTLE, then during the bitslip cycle.
    apply_reset();
    use_rot = 1'b1; rot = 3; drv_train = 1'b1; drv_valid = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      cycle();
      if (pulses == 1) break;
    end
    cycle();
    #2 RESETN = 1'b0;
    #1 check_zero("t6_settle");
    @(posedge SCLK);
    #3 RESETN = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 50; i++) begin
      cycle();
      if (pulses == 1) break;
    end
    check("t6_restart_pulse_phase", slip_cnt, 0);
    rot = (rot + 1) % 8;
    #1 RESETN = 1'b0;
    #1 check_zero("t6_slip");
    @(posedge SCLK);
    #3 RESETN = 1'b1;
    pulses = 0;
    min_gap = 1000;
    for (int i = 1; i <= 300; i++) begin
      cycle();
      if (aligned === 1'b1) break;
    end
    check("t6_pulses", pulses, 2);
    check("t6_slip_cnt", slip_cnt, 2);
    check("t6_aligned", aligned, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_word_align_ctrl.md
# rx_word_align_ctrl

Word-alignment controller for the 8-bit receive path. Sits directly downstream of the per-lane bit-order reversal stage. Compares bit-ordered parallel words against a fixed training pattern and pulses `bitslip` to the IOD until the word boundary is found. It then declares lock, forwards data, and watches for loss of alignment while training is enabled.

## Interface
- `TRAIN_PATTERN`, 8'h68: expected training word. All 8 rotations are distinct, so exactly one slip phase matches.
- `LOCK_COUNT`, 16: consecutive matching valid words required to declare lock (2..255).
- `LOSS_COUNT`, 4: consecutive mismatching valid words, while locked and training, that drop lock (1..15).
- `SLIP_SETTLE`, 4: clock cycles ignored after each bitslip pulse (1..15).

Ports:
- `SCLK`  in  1  receive parallel clock; all logic on its rising edge.
- `RESETN`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  bit-ordered word from the reversal stage.
- `rx_valid`  in  1  `rx_data` valid this cycle.
- `train_en`  in  1  level; 1 = link transmitting training pattern.
- `bitslip`  out  1  one-cycle pulse to the IOD bitslip input.
- `aligned`  out  1  lock achieved.
- `align_err`  out  1  no phase matched; sticky until `train_en` falls.
- `slip_cnt`  out  3  current slip phase, modulo 8.
- `data_out`  out  8  registered `rx_data`.
- `data_valid`  out  1  `rx_valid & aligned`, registered.

## Operation
- FSM states: IDLE, CHECK, SLIP, SETTLE, LOCKED, ERROR.
- IDLE:
  - Clears `match_cnt`, `miss_cnt`, `attempts`, and `slip_cnt`.
  - `train_en`=1 → CHECK.
- CHECK, evaluated on `rx_valid` words only:
  - Match: `match_cnt`++. When it reaches LOCK_COUNT → LOCKED.
  - Mismatch: `match_cnt` cleared. If `attempts`==7 → ERROR, else → SLIP.
- SLIP, one cycle:
  - `bitslip`=1.
  - `slip_cnt`++ with wrap 7→0.
  - `attempts`++.
  - → SETTLE.
- SETTLE:
  - Counts SLIP_SETTLE cycles, ignoring `rx_valid`.
  - Then → CHECK.
- LOCKED: `aligned`=1.
  - If `train_en`=1, each valid mismatch increments `miss_cnt` and each valid match clears it.
  - When `miss_cnt` reaches LOSS_COUNT → CHECK, with `aligned`=0 and `attempts` and `match_cnt` cleared. `slip_cnt` is kept.
  - If `train_en`=0 (payload mode), no checking is done and the state stays LOCKED.
- ERROR:
  - `align_err`=1.
  - `train_en`=0 → IDLE.
- Priority: `train_en`=0 in CHECK, SLIP, or SETTLE forces IDLE. This overrides a simultaneous lock or slip decision, and no `bitslip` is issued. The only exit from LOCKED is loss of lock or reset.
- Counters saturate at their terminal values; none wraps except `slip_cnt`.

## Timing
- Reset values: every output 0, state IDLE, all counters 0.
- Reset asserted mid-operation clears immediately, including a `bitslip` pulse in flight.
- Decision cycle: the cycle in which a valid word is compared.
  - `bitslip` is high exactly one cycle, in the cycle after a mismatch decision.
  - The earliest next compare is SLIP_SETTLE+1 cycles after the pulse.
- `aligned` rises in the cycle after the LOCK_COUNT-th consecutive matching word.
- `aligned` falls in the cycle after the LOSS_COUNT-th consecutive mismatch.
- `data_out` and `data_valid`:
  - 1-cycle latency from `rx_data` and `rx_valid`.
  - `data_out` is updated every cycle, regardless of `rx_valid`.
  - `data_valid` uses the registered `aligned`, so the word that completes lock is not forwarded valid.
- Gaps in `rx_valid` do not reset `match_cnt` or `miss_cnt`; only words are counted.

## Structure
- Package `rx_align_pkg` holds:
  - the state enum,
  - the default `TRAIN_PATTERN`,
  - the counter width constants (8-bit `match_cnt`, 4-bit `miss_cnt`, 4-bit settle counter, 4-bit `attempts`).
- Single module, no sub-modules. The bit-order reversal stays a separate upstream instance.

## Test plan
- Pattern already aligned (8'h68 every cycle, `train_en`=1):
  - No `bitslip`.
  - `aligned`=1 on the cycle after the 16th valid word; `slip_cnt`=0.
- Pattern rotated by 3 (emulated source rotates back on each `bitslip`):
  - Exactly 3 `bitslip` pulses, each separated by ≥5 cycles.
  - Lock follows; `slip_cnt`=3.
- Constant 8'h00 input:
  - 7 `bitslip` pulses, then `align_err`=1 and `aligned`=0.
  - `train_en` low → IDLE; all outputs 0 the next cycle.
- Locked, then 3 mismatches, 1 match, then 4 mismatches:
  - `aligned` stays 1 through the first burst.
  - `aligned` drops one cycle after the 4th mismatch of the second burst.
- Locked, `train_en`=0, random payload:
  - `aligned` stays 1.
  - `data_out`/`data_valid` equal `rx_data`/`rx_valid` delayed by 1 cycle.
- `RESETN` pulsed low in SETTLE and again in the `bitslip` cycle:
  - All outputs 0 asynchronously.
  - Re-alignment restarts from `slip_cnt`=0.
